inv_mix_columns_iter: RTL and testbench

Iterative AES-128 InvMixColumns unit for the decryption datapath. It accepts a 128-bit state over a valid/ready handshake and transforms one 32-bit column per cycle using the inverse matrix {0e,0b,0d,09}. It holds the result until the downstream stage accepts it. It sits between InvShiftRows/InvSubBytes/AddRoundKey stages of the iterative decrypt round, mirroring the combinational forward MixColumns used in encryption.

---
 rtl/aes_pkg.sv | 76 +++++++
 rtl/inv_mix_col_word.sv | 36 +++
 rtl/inv_mix_columns_iter.sv | 103 ++++++++++
 tb/tb_inv_mix_columns_iter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type and GF(2^8) helpers for the MixColumns datapath.
// Column c of a 128-bit state occupies bits [127-32c -: 32], with row 0 in the MSB byte.
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_COL_W   = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } imc_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul02(input logic [7:0] b);
        return xtime(b);
    endfunction

    function automatic logic [7:0] gf_mul03(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gf_mul09(input logic [7:0] b);
        logic [7:0] x8;
        x8 = xtime(xtime(xtime(b)));
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul0b(input logic [7:0] b);
        logic [7:0] x2;
        logic [7:0] x8;
        x2 = xtime(b);
        x8 = xtime(xtime(x2));
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul0d(input logic [7:0] b);
        logic [7:0] x4;
        logic [7:0] x8;
        x4 = xtime(xtime(b));
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul0e(input logic [7:0] b);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    function automatic logic [AES_COL_W-1:0] col_get(input logic [AES_STATE_W-1:0] s,
                                                      input logic [1:0] c);
        int base;
        base = 96 - 32 * int'(c);
        return s[base +: AES_COL_W];
    endfunction

    function automatic logic [AES_STATE_W-1:0] col_set(input logic [AES_STATE_W-1:0] s,
                                                        input logic [1:0] c,
                                                        input logic [AES_COL_W-1:0] w);
        logic [AES_STATE_W-1:0] r;
        int base;
        r    = s;
        base = 96 - 32 * int'(c);
        r[base +: AES_COL_W] = w;
        return r;
    endfunction

endpackage

// File: rtl/inv_mix_col_word.sv
// One-column InvMixColumns transform (combinational). With INV_MIX_FWD_MODE_EN defined,
// i_mode=1 selects the forward MixColumns matrix instead.
module inv_mix_col_word
    import aes_pkg::*;
(
`ifdef INV_MIX_FWD_MODE_EN
    input  logic                 i_mode,
`endif
    input  logic [AES_COL_W-1:0] i_col,
    output logic [AES_COL_W-1:0] o_col
);

    logic [7:0] w_a   [4];
    logic [7:0] w_inv [4];
`ifdef INV_MIX_FWD_MODE_EN
    logic [7:0] w_fwd [4];
`endif

    // Each matrix row is the row-0 coefficients rotated right by the row index.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_row
            assign w_a[gi]   = i_col[31-8*gi -: 8];
            assign w_inv[gi] = gf_mul0e(w_a[gi])       ^ gf_mul0b(w_a[(gi+1)%4]) ^
                               gf_mul0d(w_a[(gi+2)%4]) ^ gf_mul09(w_a[(gi+3)%4]);
`ifdef INV_MIX_FWD_MODE_EN
            assign w_fwd[gi] = gf_mul02(w_a[gi]) ^ gf_mul03(w_a[(gi+1)%4]) ^
                               w_a[(gi+2)%4]     ^ w_a[(gi+3)%4];
            assign o_col[31-8*gi -: 8] = i_mode ? w_fwd[gi] : w_inv[gi];
`else
            assign o_col[31-8*gi -: 8] = w_inv[gi];
`endif
        end
    endgenerate

endmodule

// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns: one column per cycle, valid/ready in and out.
// Optional INV_MIX_FWD_MODE_EN adds a mode port selecting forward MixColumns.
module inv_mix_columns_iter
    import aes_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_data
`ifdef INV_MIX_FWD_MODE_EN
    ,
    input  logic                   mode
`endif
);

    imc_state_e             r_state;
    imc_state_e             w_state_next;
    logic [1:0]             r_col;
    logic [AES_STATE_W-1:0] r_work;
    logic [AES_COL_W-1:0]   w_col_in;
    logic [AES_COL_W-1:0]   w_col_out;

    assign w_col_in = col_get(r_work, r_col);

`ifdef INV_MIX_FWD_MODE_EN
    logic r_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= 1'b0;
        end else if (r_state == IDLE && in_valid) begin
            r_mode <= mode;
        end
    end

    inv_mix_col_word u_col (
        .i_mode (r_mode),
        .i_col  (w_col_in),
        .o_col  (w_col_out)
    );
`else
    inv_mix_col_word u_col (
        .i_col  (w_col_in),
        .o_col  (w_col_out)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Outputs are pure state/register decodes, so no input reaches an output combinationally.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_data     = r_work;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_next = BUSY;
            end
            BUSY: begin
                if (r_col == 2'd3) w_state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col  <= 2'd0;
            r_work <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_work <= in_data;
                        r_col  <= 2'd0;
                    end
                end
                BUSY: begin
                    r_work <= col_set(r_work, r_col, w_col_out);
                    r_col  <= r_col + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Directed self-checking bench for inv_mix_columns_iter (forward-mode checks need INV_MIX_FWD_MODE_EN).
module tb_inv_mix_columns_iter;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
`ifdef INV_MIX_FWD_MODE_EN
    logic         mode;
`endif

    int checks;
    int failures;

    inv_mix_columns_iter dut (
`ifdef INV_MIX_FWD_MODE_EN
        .mode      (mode),
`endif
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] FULL_IN  = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
    localparam logic [127:0] FULL_OUT = 128'hdb135345_f20a225c_01010101_2d26314c;

    // Present d until accepted; caller is #1 after a rising edge. Afterwards in_data is scrambled.
    task automatic accept(input logic [127:0] d, output logic ok);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        ok = in_ready;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = ~d;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef INV_MIX_FWD_MODE_EN
        mode      = 1'b0;
`endif
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++;
        if (out_data !== 128'h0) begin failures++; $display("FAIL reset_out_data got=%h want=0", out_data); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_flags got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        $display("reset: in_ready=%b out_valid=%b out_data=%h", in_ready, out_valid, out_data);
    endtask

    task automatic test_columns();
        logic [127:0] vin  [5];
        logic [127:0] vexp [5];
        logic ok;
        int lat;
        vin[0]  = {32'h8e4da1bc, 96'h0};
        vexp[0] = {32'hdb135345, 96'h0};
        vin[1]  = {32'h0, 32'h9fdc589d, 64'h0};
        vexp[1] = {32'h0, 32'hf20a225c, 64'h0};
        vin[2]  = {64'h0, 32'h01010101, 32'h0};
        vexp[2] = {64'h0, 32'h01010101, 32'h0};
        vin[3]  = {96'h0, 32'h4d7ebdf8};
        vexp[3] = {96'h0, 32'h2d26314c};
        vin[4]  = FULL_IN;
        vexp[4] = FULL_OUT;
        for (int i = 0; i < 5; i++) begin
            accept(vin[i], ok);
            wait_out(lat);
            checks++;
            if (lat != 4 || !ok) begin
                failures++;
                $display("FAIL col_latency[%0d] got=%0d want=4 (accepted=%b)", i, lat, ok);
            end
            checks++;
            if (out_data !== vexp[i]) begin
                failures++;
                $display("FAIL col_data[%0d] got=%h want=%h", i, out_data, vexp[i]);
            end
            $display("xfer %0d: in=%h out=%h lat=%0d", i, vin[i], out_data, lat);
            release_out();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL col_release[%0d] got out_valid=%b in_ready=%b want 0/1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        logic ok;
        int lat;
        int bad;
        accept(FULL_IN, ok);
        wait_out(lat);
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_first_valid got=%b want=1", out_valid); end
        in_valid = 1'b1;
        in_data  = 128'hdeadbeef_cafef00d_12345678_9abcdef0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== FULL_OUT || in_ready !== 1'b0) begin
                failures++;
                bad++;
                $display("FAIL bp_hold[%0d] got valid=%b data=%h in_ready=%b want 1/%h/0",
                         i, out_valid, out_data, in_ready, FULL_OUT);
            end
        end
        in_valid = 1'b0;
        release_out();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL bp_no_capture[%0d] got out_valid=%b in_ready=%b want 0/1", i, out_valid, in_ready);
            end
            @(posedge clk); #1;
        end
        $display("backpressure: held 10 cycles out=%h bad_cycles=%0d", FULL_OUT, bad);
    endtask

    task automatic test_back_to_back();
        logic [127:0] vin  [2];
        logic [127:0] vexp [2];
        int acc_cyc [2];
        int out_cyc [2];
        int acc;
        int outn;
        vin[0]  = FULL_IN;
        vexp[0] = FULL_OUT;
        vin[1]  = {32'h4d7ebdf8, 32'h01010101, 32'h9fdc589d, 32'h8e4da1bc};
        vexp[1] = {32'h2d26314c, 32'h01010101, 32'hf20a225c, 32'hdb135345};
        acc = 0;
        outn = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (acc < 2) begin
                in_valid = 1'b1;
                in_data  = vin[acc];
            end else begin
                in_valid = 1'b0;
            end
            if (in_valid && in_ready) begin
                acc_cyc[acc] = cyc;
                acc++;
            end
            if (out_valid && outn < 2) begin
                checks++;
                if (out_data !== vexp[outn]) begin
                    failures++;
                    $display("FAIL b2b_data[%0d] got=%h want=%h", outn, out_data, vexp[outn]);
                end
                $display("b2b out %0d: data=%h cycle=%0d", outn, out_data, cyc);
                out_cyc[outn] = cyc;
                outn++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (acc != 2 || outn != 2) begin
            failures++;
            $display("FAIL b2b_count got accepts=%0d outputs=%0d want 2/2", acc, outn);
        end else begin
            checks++;
            if (acc_cyc[1] - acc_cyc[0] != 6) begin
                failures++;
                $display("FAIL b2b_spacing got=%0d want=6", acc_cyc[1] - acc_cyc[0]);
            end
            // Sampling happens the half-cycle before the accept edge, so 4-cycle latency shows as 5.
            checks++;
            if (out_cyc[0] - acc_cyc[0] != 5 || out_cyc[1] - acc_cyc[1] != 5) begin
                failures++;
                $display("FAIL b2b_latency got=%0d,%0d want=5,5",
                         out_cyc[0] - acc_cyc[0], out_cyc[1] - acc_cyc[1]);
            end
        end
    endtask

    task automatic test_reset_abort();
        logic ok;
        int lat;
        accept(FULL_IN, ok);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 128'h0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL abort_outputs got valid=%b data=%h in_ready=%b want 0/0/1", out_valid, out_data, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL abort_no_output[%0d] got=%b want=0", i, out_valid);
            end
            @(posedge clk); #1;
        end
        accept(FULL_IN, ok);
        wait_out(lat);
        checks++;
        if (out_data !== FULL_OUT || lat != 4) begin
            failures++;
            $display("FAIL abort_fresh got=%h lat=%0d want=%h lat=4", out_data, lat, FULL_OUT);
        end
        $display("abort: fresh result=%h lat=%0d", out_data, lat);
        release_out();
    endtask

`ifdef INV_MIX_FWD_MODE_EN
    task automatic test_fwd_roundtrip();
        logic ok;
        int lat;
        logic [127:0] rnd;
        logic [127:0] mid;
        mode = 1'b1;
        accept(FULL_OUT, ok);
        wait_out(lat);
        checks++;
        if (out_data !== FULL_IN || lat != 4) begin
            failures++;
            $display("FAIL fwd_vector got=%h lat=%0d want=%h lat=4", out_data, lat, FULL_IN);
        end
        mid = out_data;
        release_out();
        mode = 1'b0;
        accept(mid, ok);
        wait_out(lat);
        checks++;
        if (out_data !== FULL_OUT) begin
            failures++;
            $display("FAIL fwd_restore got=%h want=%h", out_data, FULL_OUT);
        end
        release_out();
        rnd = {$urandom, $urandom, $urandom, $urandom};
        mode = 1'b1;
        accept(rnd, ok);
        wait_out(lat);
        mid = out_data;
        release_out();
        mode = 1'b0;
        accept(mid, ok);
        wait_out(lat);
        checks++;
        if (out_data !== rnd) begin
            failures++;
            $display("FAIL fwd_random got=%h want=%h", out_data, rnd);
        end
        $display("roundtrip: rnd=%h mid=%h back=%h", rnd, mid, out_data);
        release_out();
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_columns();
        test_backpressure();
        test_back_to_back();
        test_reset_abort();
`ifdef INV_MIX_FWD_MODE_EN
        test_fwd_roundtrip();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
